// File: rtl/nor_seq_pkg.sv
// nor_seq_pkg: shared encodings for the NOR sequencer (ops, sources, destinations, micro-op record).
package nor_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOR, OP_OR, OP_AND, OP_NAND, OP_XOR, OP_XNOR, OP_NOT, OP_RSV
    } op_t;

    // SRC_ONE is a tied-high input so the reserved op can produce R=0 through the NOR.
    typedef enum logic [2:0] {
        SRC_A, SRC_B, SRC_T1, SRC_T2, SRC_T3, SRC_R, SRC_ONE
    } src_t;

    typedef enum logic [1:0] {DST_T1, DST_T2, DST_T3, DST_R} dst_t;

    typedef struct packed {
        src_t src_x;
        src_t src_y;
        dst_t dst;
        logic last;
    } uop_t;

    function automatic uop_t mk(src_t x, src_t y, dst_t d, logic l);
        return '{src_x: x, src_y: y, dst: d, last: l};
    endfunction

endpackage

// File: rtl/nor_seq_rom.sv
// nor_seq_rom: combinational (op, step) -> micro-op table; last marks the final step of a bit.
module nor_seq_rom
    import nor_seq_pkg::*;
(
    input  op_t        op,
    input  logic [2:0] step,
    output uop_t       uop
);

    always_comb begin
        uop = mk(SRC_ONE, SRC_ONE, DST_R, 1'b1);
        case (op)
            OP_NOR: uop = mk(SRC_A, SRC_B, DST_R, 1'b1);
            OP_NOT: uop = mk(SRC_A, SRC_A, DST_R, 1'b1);
            OP_OR:  uop = step == 3'd0 ? mk(SRC_A, SRC_B, DST_T1, 1'b0) : mk(SRC_T1, SRC_T1, DST_R, 1'b1);
            OP_AND, OP_NAND:
                case (step)
                    3'd0:    uop = mk(SRC_A, SRC_A, DST_T1, 1'b0);
                    3'd1:    uop = mk(SRC_B, SRC_B, DST_T2, 1'b0);
                    3'd2:    uop = mk(SRC_T1, SRC_T2, DST_R, op == OP_AND);
                    default: uop = mk(SRC_R, SRC_R, DST_R, 1'b1);
                endcase
            OP_XOR, OP_XNOR:
                case (step)
                    3'd0:    uop = mk(SRC_A, SRC_B, DST_T1, 1'b0);
                    3'd1:    uop = mk(SRC_A, SRC_T1, DST_T2, 1'b0);
                    3'd2:    uop = mk(SRC_B, SRC_T1, DST_T3, 1'b0);
                    3'd3:    uop = mk(SRC_T2, SRC_T3, DST_R, op == OP_XNOR);
                    default: uop = mk(SRC_R, SRC_R, DST_R, 1'b1);
                endcase
            default: uop = mk(SRC_ONE, SRC_ONE, DST_R, 1'b1);
        endcase
    end

endmodule

// File: rtl/nor_sequencer.sv
// nor_sequencer: bit-serial logic unit stepping one shared NOR per clock through per-op micro-sequences.
// Define NOR_SEQ_CNT_EN to add the saturating 32-bit nor_count output.
module nor_sequencer
    import nor_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef NOR_SEQ_CNT_EN
    output logic [31:0]      nor_count,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]       state;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             t1, t2, t3;
    logic [BW-1:0]    bit_idx;
    logic [2:0]       step;
    uop_t             uop;
    logic [7:0]       src_vec;
    logic             x, y, nor_out;

    nor_seq_rom u_rom (.op(op_q), .step(step), .uop(uop));

    assign src_vec = {2'b11, result[bit_idx], t3, t2, t1, b_q[bit_idx], a_q[bit_idx]};
    assign x = src_vec[uop.src_x];
    assign y = src_vec[uop.src_y];

    nor u_nor (nor_out, x, y);

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_NOR;
            a_q     <= '0;
            b_q     <= '0;
            {t1, t2, t3} <= '0;
            bit_idx <= '0;
            step    <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE:
                    if (start) begin
                        op_q    <= op_t'(op);
                        a_q     <= a;
                        b_q     <= b;
                        {t1, t2, t3} <= '0;
                        bit_idx <= '0;
                        step    <= '0;
                        result  <= '0;
                        state   <= RUN;
                    end
                RUN: begin
                    case (uop.dst)
                        DST_T1:  t1 <= nor_out;
                        DST_T2:  t2 <= nor_out;
                        DST_T3:  t3 <= nor_out;
                        default: result[bit_idx] <= nor_out;
                    endcase
                    if (uop.last) begin
                        step <= '0;
                        if (bit_idx == BW'(WIDTH - 1)) state <= DONE;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NOR_SEQ_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) nor_count <= '0;
        else if (state == RUN && nor_count != '1) nor_count <= nor_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_nor_sequencer.sv
// tb_nor_sequencer: directed tests at WIDTH=4 against a truth-table/latency model of the NOR sequencer.
module tb_nor_sequencer;

    localparam int W = 4;

    logic         clk = 0, reset = 1, start = 0;
    logic [2:0]   op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic         busy, done;
    logic [W-1:0] result;
`ifdef NOR_SEQ_CNT_EN
    logic [31:0]  nor_count;
`endif

    int n_checks = 0, n_fail = 0;

    nor_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done),
`ifdef NOR_SEQ_CNT_EN
        .nor_count(nor_count),
`endif
        .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] f(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
        case (o)
            3'd0:    return ~(x | y);
            3'd1:    return x | y;
            3'd2:    return x & y;
            3'd3:    return ~(x & y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return '0;
        endcase
    endfunction

    function automatic int steps(logic [2:0] o);
        case (o)
            3'd1:    return 2;
            3'd2:    return 3;
            3'd3:    return 4;
            3'd4:    return 5;
            3'd5:    return 4;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request accepted when idle keeps the unit busy W*S+1 cycles, done on the last.
    int           m_left, m_cnt;
    logic [W-1:0] m_exp, m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_res  <= '0;
            m_cnt  <= 0;
        end else if (m_left > 0) begin
            if (m_left > 1) m_cnt <= m_cnt + 1;
            if (m_left == 2) m_res <= m_exp;
            m_left <= m_left - 1;
        end else if (start) begin
            m_left <= W * steps(op) + 1;
            m_exp  <= f(op, a, b);
            m_res  <= '0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("done", 32'(done), 32'(m_left == 1));
            if (m_left == 0 || m_left == 1) chk("result", 32'(result), 32'(m_res));
`ifdef NOR_SEQ_CNT_EN
            chk("nor_count", nor_count, 32'(m_cnt));
`endif
        end
    end

    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp_r, input int exp_n, input int poke, input string name);
        int n;
        @(negedge clk);
        op = o; a = x; b = y; start = 1;
        @(negedge clk);
        start = 0;
        op = 3'd7; a = '1; b = '0;
        for (n = 1; n < 100; n++) begin
            if (done) break;
            start = (n == poke);
            if (n == poke) begin op = 3'd2; a = 4'b1111; b = 4'b1111; end
            @(negedge clk);
        end
        start = 0;
        chk({name, "_done_cycle"}, 32'(n), 32'(exp_n));
        chk({name, "_result"}, 32'(result), 32'(exp_r));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
`ifdef NOR_SEQ_CNT_EN
        chk("reset_count", nor_count, 32'd0);
`endif
        run(3'd2, 4'b1100, 4'b1010, 4'b1000, 13, 0, "and");
        run(3'd4, 4'b1100, 4'b1010, 4'b0110, 21, 0, "xor");
`ifdef NOR_SEQ_CNT_EN
        chk("count_and_xor", nor_count, 32'd32);
`endif
        run(3'd5, 4'b1100, 4'b1010, 4'b1001, 17, 0, "xnor");
        run(3'd6, 4'b0101, 4'b0000, 4'b1010, 5, 0, "not");
        run(3'd0, 4'b0000, 4'b0000, 4'b1111, 5, 0, "nor");
        run(3'd7, 4'b1011, 4'b0110, 4'b0000, 5, 0, "rsv");
        run(3'd1, 4'b0011, 4'b0101, 4'b0111, 9, 3, "or_ignore");
        // Reset in the middle of an XOR run.
        @(negedge clk);
        op = 3'd4; a = 4'b1100; b = 4'b1010; start = 1;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        reset = 1;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 0;
        run(3'd3, 4'b1111, 4'b0110, 4'b1001, 17, 0, "nand");
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
